// File: rtl/dft_power_peak.sv
// dft_power_peak: output stage of the 16-point DFT array.
// It captures one frame of complex bins and rescales each bin from Q17 to an integer.
// It then streams |X[k]|^2 one bin per accepted beat and reports the strongest bin once per frame.
module dft_power_peak #(
  parameter  int DW      = 28,
  parameter  int SHIFT   = 17,
  parameter  int HALF    = 1,
  parameter  int SKIP_DC = 1,
  localparam int SW      = DW - SHIFT,
  localparam int PW      = 2 * SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] R0,
  input  logic [DW-1:0] R1,
  input  logic [DW-1:0] R2,
  input  logic [DW-1:0] R3,
  input  logic [DW-1:0] R4,
  input  logic [DW-1:0] R5,
  input  logic [DW-1:0] R6,
  input  logic [DW-1:0] R7,
  input  logic [DW-1:0] R8,
  input  logic [DW-1:0] R9,
  input  logic [DW-1:0] R10,
  input  logic [DW-1:0] R11,
  input  logic [DW-1:0] R12,
  input  logic [DW-1:0] R13,
  input  logic [DW-1:0] R14,
  input  logic [DW-1:0] R15,
  input  logic [DW-1:0] I0,
  input  logic [DW-1:0] I1,
  input  logic [DW-1:0] I2,
  input  logic [DW-1:0] I3,
  input  logic [DW-1:0] I4,
  input  logic [DW-1:0] I5,
  input  logic [DW-1:0] I6,
  input  logic [DW-1:0] I7,
  input  logic [DW-1:0] I8,
  input  logic [DW-1:0] I9,
  input  logic [DW-1:0] I10,
  input  logic [DW-1:0] I11,
  input  logic [DW-1:0] I12,
  input  logic [DW-1:0] I13,
  input  logic [DW-1:0] I14,
  input  logic [DW-1:0] I15,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] pw_data,
  output logic [3:0]    pw_bin,
  output logic          pw_last,
  output logic          pw_valid,
  input  logic          pw_ready,
  output logic [3:0]    peak_bin,
  output logic [PW-1:0] peak_pow,
  output logic          peak_valid
);

  // Number of bins emitted per frame; with real input the upper half mirrors the lower half.
  localparam logic [4:0] NB   = (HALF != 0) ? 5'd9 : 5'd16;
  localparam logic [4:0] LAST = NB - 5'd1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        [DW-1:0] r_in  [16];
  logic        [DW-1:0] i_in  [16];
  logic signed [DW-1:0] r_buf [16];
  logic signed [DW-1:0] i_buf [16];

  logic [4:0]           k;
  logic signed [SW-1:0] r_s;
  logic signed [SW-1:0] i_s;
  logic signed [PW-1:0] r_x;
  logic signed [PW-1:0] i_x;
  logic [PW-1:0]        pow_next;

  logic capture;
  logic slot_free;
  logic bin_left;
  logic load;
  logic beat_done;
  logic eligible;

  logic [PW-1:0] max_pow;
  logic [3:0]    max_bin;
  logic          max_set;

  assign r_in = '{R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15};
  assign i_in = '{I0, I1, I2, I3, I4, I5, I6, I7, I8, I9, I10, I11, I12, I13, I14, I15};

  // A new frame is only taken while idle; in_valid during RUN has no effect.
  assign capture   = (state_q == IDLE) && in_valid;
  assign slot_free = !pw_valid || pw_ready;
  assign bin_left  = (k < NB);
  assign load      = (state_q == RUN) && slot_free && bin_left;
  assign beat_done = (state_q == RUN) && pw_valid && pw_ready && pw_last;
  assign eligible  = !((SKIP_DC != 0) && (k == 5'd0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame handshake: accept a frame in IDLE, return once the last beat is taken.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame buffer; its contents are only read in RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int j = 0; j < 16; j++) begin
        r_buf[j] <= r_in[j];
        i_buf[j] <= i_in[j];
      end
    end
  end

  // Rescale the selected bin (floor shift) and form r^2 + i^2; the sum fits PW bits without saturation.
  always_comb begin
    r_s      = SW'(r_buf[k[3:0]] >>> SHIFT);
    i_s      = SW'(i_buf[k[3:0]] >>> SHIFT);
    r_x      = PW'(r_s);
    i_x      = PW'(i_s);
    pow_next = r_x * r_x + i_x * i_x;
  end

  // Output beat register and bin counter: load a bin whenever the slot is free, and hold it while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= 5'd0;
      pw_data  <= '0;
      pw_bin   <= 4'd0;
      pw_last  <= 1'b0;
      pw_valid <= 1'b0;
    end else if (capture) begin
      k <= 5'd0;
    end else if ((state_q == RUN) && slot_free) begin
      if (bin_left) begin
        pw_data  <= pow_next;
        pw_bin   <= k[3:0];
        pw_last  <= (k == LAST);
        pw_valid <= 1'b1;
        k        <= k + 5'd1;
      end else begin
        pw_valid <= 1'b0;
      end
    end
  end

  // Running maximum (strictly greater wins, so ties keep the lower bin), published when the last beat is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_pow    <= '0;
      max_bin    <= 4'd0;
      max_set    <= 1'b0;
      peak_bin   <= 4'd0;
      peak_pow   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (capture) begin
        max_pow <= '0;
        max_bin <= 4'd0;
        max_set <= 1'b0;
      end else if (load && eligible && (!max_set || (pow_next > max_pow))) begin
        max_pow <= pow_next;
        max_bin <= k[3:0];
        max_set <= 1'b1;
      end
      if (beat_done) begin
        peak_bin   <= max_bin;
        peak_pow   <= max_pow;
        peak_valid <= 1'b1;
      end
    end
  end

endmodule
